// File: rtl/aurora_link_supervisor.sv
// Aurora bring-up supervisor: drives init_rst, qualifies channel_up, retries on timeout/drop/hard_err.
// Latency channel_up->link_ready = SYNC_STAGES+STABLE_CYCLES+1; no backpressure, outputs registered off the next-state decode.
module aurora_link_supervisor #(
    parameter int SYNC_STAGES    = 2,
    parameter int RESET_PULSE    = 16,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int STABLE_CYCLES  = 256,
    parameter int MAX_RETRIES    = 8,
    parameter int CNT_W          = 24,
    parameter int RETRY_W        = 8
) (
    input  logic               init_clk,
    input  logic               RST,
    input  logic               channel_up,
    input  logic               hard_err,
    output logic               init_rst,
    output logic               link_ready,
    output logic               link_fail,
    output logic [RETRY_W-1:0] retry_cnt,
    output logic [2:0]         state_o
);

    typedef enum logic [2:0] {
        S_RESET   = 3'd0,
        S_WAIT_UP = 3'd1,
        S_QUALIFY = 3'd2,
        S_UP      = 3'd3,
        S_FAIL    = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0]   PULSE_LAST  = CNT_W'(RESET_PULSE - 1);
    localparam logic [CNT_W-1:0]   TO_LAST     = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] FAIL_LIMIT  = RETRY_W'(MAX_RETRIES);
    localparam bit                 LIMITED     = (MAX_RETRIES != 0);

    logic [SYNC_STAGES-1:0] ch_up_sync_q, herr_sync_q;
    logic                   ch_up_s, herr_s;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     pulse_q, pulse_d;
    logic [CNT_W-1:0]     timer_q, timer_d;
    logic [CNT_W-1:0]     stable_q, stable_d;
    logic [RETRY_W-1:0]   fail_q, fail_d;
    logic [RETRY_W-1:0]   retry_q, retry_d;
    logic                 retry_ev;
    logic                 init_rst_q, init_rst_d;
    logic                 ready_q, ready_d;
    logic                 fail_flag_q, fail_flag_d;

    always_ff @(posedge init_clk) begin
        if (RST) begin
            ch_up_sync_q <= '0;
            herr_sync_q  <= '0;
        end else begin
            ch_up_sync_q <= {ch_up_sync_q[SYNC_STAGES-2:0], channel_up};
            herr_sync_q  <= {herr_sync_q[SYNC_STAGES-2:0], hard_err};
        end
    end

    assign ch_up_s = ch_up_sync_q[SYNC_STAGES-1];
    assign herr_s  = herr_sync_q[SYNC_STAGES-1];

    always_ff @(posedge init_clk) begin
        if (RST) begin
            state_q     <= S_RESET;
            pulse_q     <= '0;
            timer_q     <= '0;
            stable_q    <= '0;
            fail_q      <= '0;
            retry_q     <= '0;
            init_rst_q  <= 1'b1;
            ready_q     <= 1'b0;
            fail_flag_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pulse_q     <= pulse_d;
            timer_q     <= timer_d;
            stable_q    <= stable_d;
            fail_q      <= fail_d;
            retry_q     <= retry_d;
            init_rst_q  <= init_rst_d;
            ready_q     <= ready_d;
            fail_flag_q <= fail_flag_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pulse_d  = pulse_q;
        timer_d  = timer_q;
        stable_d = stable_q;
        fail_d   = fail_q;
        retry_d  = retry_q;
        retry_ev = 1'b0;
        case (state_q)
            S_RESET: begin
                if (pulse_q == PULSE_LAST) begin
                    state_d = S_WAIT_UP;
                    pulse_d = '0;
                end else begin
                    pulse_d = pulse_q + 1'b1;
                end
            end
            // A rising channel_up takes priority over an expiring timer.
            S_WAIT_UP: begin
                if (ch_up_s)                 state_d  = S_QUALIFY;
                else if (timer_q == TO_LAST) retry_ev = 1'b1;
                else                         timer_d  = timer_q + 1'b1;
            end
            S_QUALIFY: begin
                if (herr_s) begin
                    retry_ev = 1'b1;
                end else if (!ch_up_s) begin
                    state_d  = S_WAIT_UP;
                    stable_d = '0;
                end else if (stable_q == STABLE_LAST) begin
                    state_d  = S_UP;
                    stable_d = '0;
                    timer_d  = '0;
                    fail_d   = '0;
                end else begin
                    stable_d = stable_q + 1'b1;
                end
            end
            S_UP: begin
                if (!ch_up_s || herr_s) retry_ev = 1'b1;
            end
            S_FAIL: ;
            default: state_d = S_RESET;
        endcase

        if (retry_ev) begin
            if (LIMITED && fail_q == FAIL_LIMIT) begin
                state_d = S_FAIL;
            end else begin
                state_d  = S_RESET;
                pulse_d  = '0;
                timer_d  = '0;
                stable_d = '0;
                fail_d   = (fail_q == '1) ? fail_q : fail_q + 1'b1;
                retry_d  = (retry_q == '1) ? retry_q : retry_q + 1'b1;
            end
        end
    end

    always_comb begin
        init_rst_d  = (state_d == S_RESET);
        ready_d     = (state_d == S_UP);
        fail_flag_d = (state_d == S_FAIL);
    end

    assign init_rst   = init_rst_q;
    assign link_ready = ready_q;
    assign link_fail  = fail_flag_q;
    assign retry_cnt  = retry_q;
    assign state_o    = state_q;

endmodule
